// File: rtl/mux21x8_arb_if.sv
// Handshake bundle for mux21x8_arb: two byte producers (A, B) and one byte consumer.
// master = producers/consumer side, slave = the arbiter.
interface mux21x8_arb_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_last;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_last;
  logic       b_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_src;
  logic       out_ready;

  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/mux21x8_arb.sv
// Round-robin, burst-locked arbiter driving a 2:1 byte mux into a one-entry output register.
// Define MUX21X8_ARB_BURST_LIMIT_EN to force rotation after MAX_BURST beats.
module mux21x8_arb #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic          clk,
  input logic          resetb,
  mux21x8_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLockA, StLockB} state_e;

  state_e     state_q, state_d;
  logic       last_srv_q, last_srv_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       out_src_q, out_src_d;

  logic       sel;
  logic [7:0] mux_y;
  logic       x_valid, x_last, other_valid;
  logic       can_load, xfer, burst_hit, release_x;

  // mux21x8 datapath: s=0 passes A, s=1 passes B
  assign sel         = (state_q == StLockB);
  assign mux_y       = sel ? bus.b_data : bus.a_data;
  assign x_valid     = sel ? bus.b_valid : bus.a_valid;
  assign x_last      = sel ? bus.b_last : bus.a_last;
  assign other_valid = sel ? bus.a_valid : bus.b_valid;

  assign can_load    = ~out_valid_q | bus.out_ready;
  assign bus.a_ready = (state_q == StLockA) & can_load;
  assign bus.b_ready = (state_q == StLockB) & can_load;
  assign xfer        = x_valid & (bus.a_ready | bus.b_ready);

`ifdef MUX21X8_ARB_BURST_LIMIT_EN
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc   = cnt_q + CntW'(1);
  assign burst_hit = (cnt_inc == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (release_x) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_max_burst;
  assign unused_max_burst = ^MAX_BURST;
  assign burst_hit        = 1'b0;
`endif

  assign release_x = xfer & (x_last | burst_hit);

  always_comb begin
    state_d     = state_q;
    last_srv_d  = last_srv_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
      out_last_d  = x_last;
      out_src_d   = sel;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.a_valid && bus.b_valid) begin
          state_d = last_srv_q ? StLockA : StLockB;
        end else if (bus.a_valid) begin
          state_d = StLockA;
        end else if (bus.b_valid) begin
          state_d = StLockB;
        end
      end
      StLockA, StLockB: begin
        // Hand over on the releasing edge so the other side sees no bubble
        if (release_x) begin
          last_srv_d = sel;
          if (other_valid) begin
            state_d = sel ? StLockA : StLockB;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q     <= StIdle;
      last_srv_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_srv_q  <= last_srv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;

endmodule
